// File: rtl/sram_readback_tx.sv
// sram_readback_tx
//
// Streams a range of emulation-SRAM words to the host through the FT240X
// transmit FIFO, high byte first, so the host can verify a loaded image.
// Started by a one-cycle strobe; drives the SRAM address/OE and the FT240X
// WR#/data lines only while busy (the top level muxes them in on busy=1).
//
// Per word, with TXE low: RD, LATCH, WAIT_HI, STROBE_HI, RELEASE_HI,
// WAIT_LO, STROBE_LO, RELEASE_LO, NEXT -> 9 cycles. DONE follows the last
// NEXT and lasts one cycle.
//
// Optional feature macro: READBACK_CHECKSUM_EN
//   When defined, one extra byte (sum modulo 256 of every data byte sent)
//   goes out through CK_WAIT, CK_STROBE, CK_RELEASE before DONE.
//
// Handshake: start is a single-cycle request accepted only in IDLE (and so
// ignored while busy or in the DONE cycle). On the FT240X side a byte is
// written only from a WAIT state that saw TXE=0; the data is presented one
// cycle before nWR falls and held one cycle after nWR rises, and a TXE rise
// after that decision never aborts the byte in flight.
//
// All control outputs are registers loaded from the next state, so nWR and
// OE cannot glitch while several state bits change on the same edge. The
// asynchronous reset forces every output to its idle value at once.

module sram_readback_tx #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 8
) (
    input  logic              clk24MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_nOE,
    input  logic [15:0]       sram_data,
    input  logic              ft240x_TXE,
    output logic              ft240x_nWR,
    output logic [7:0]        ft240x_d_out,
    output logic              ft240x_d_oe,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RD         = 4'd1,
        S_LATCH      = 4'd2,
        S_WAIT_HI    = 4'd3,
        S_STROBE_HI  = 4'd4,
        S_RELEASE_HI = 4'd5,
        S_WAIT_LO    = 4'd6,
        S_STROBE_LO  = 4'd7,
        S_RELEASE_LO = 4'd8,
        S_NEXT       = 4'd9,
        S_DONE       = 4'd10,
        S_CK_WAIT    = 4'd11,
        S_CK_STROBE  = 4'd12,
        S_CK_RELEASE = 4'd13
    } state_t;

    state_t state;
    state_t state_next;

    // Address counter; it is the registered SRAM address output.
    logic [ADDR_W-1:0] addr_q;
    // One bit wider than the count input so that 2^CNT_W words fit.
    logic [CNT_W:0]    remain_q;
    // The high byte goes straight into the output register at the end of
    // LATCH; only the low byte needs to wait here for its turn.
    logic [7:0]        lo_latch_q;

    logic              busy_q;
    logic              done_q;
    logic              noe_q;
    logic              nwr_q;
    logic              doe_q;
    logic [7:0]        dout_q;

    logic [CNT_W:0]    remain_load;
    logic              last_word;

`ifdef READBACK_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    // A count of zero stands for the full 2^CNT_W words.
    assign remain_load = (word_count == '0) ? {1'b1, {CNT_W{1'b0}}}
                                            : {1'b0, word_count};
    assign last_word   = (remain_q == (CNT_W+1)'(1));

    // State register.
    always_ff @(posedge clk24MHz or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; TXE is looked at only in the WAIT states.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       if (start) state_next = S_RD;
            S_RD:         state_next = S_LATCH;
            S_LATCH:      state_next = S_WAIT_HI;
            S_WAIT_HI:    if (!ft240x_TXE) state_next = S_STROBE_HI;
            S_STROBE_HI:  state_next = S_RELEASE_HI;
            S_RELEASE_HI: state_next = S_WAIT_LO;
            S_WAIT_LO:    if (!ft240x_TXE) state_next = S_STROBE_LO;
            S_STROBE_LO:  state_next = S_RELEASE_LO;
            S_RELEASE_LO: state_next = S_NEXT;
            S_NEXT: begin
                if (last_word) begin
`ifdef READBACK_CHECKSUM_EN
                    state_next = S_CK_WAIT;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_RD;
                end
            end
`ifdef READBACK_CHECKSUM_EN
            S_CK_WAIT:    if (!ft240x_TXE) state_next = S_CK_STROBE;
            S_CK_STROBE:  state_next = S_CK_RELEASE;
            S_CK_RELEASE: state_next = S_DONE;
`endif
            S_DONE:       state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // Address/count counters and the low-byte latch.
    always_ff @(posedge clk24MHz or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            lo_latch_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= start_addr;
                        remain_q <= remain_load;
                    end
                end
                S_LATCH: begin
                    lo_latch_q <= sram_data[7:0];
                end
                S_NEXT: begin
                    // Natural wrap modulo 2^ADDR_W.
                    addr_q   <= addr_q + ADDR_W'(1);
                    remain_q <= remain_q - (CNT_W+1)'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef READBACK_CHECKSUM_EN
    // Running sum of data bytes: cleared on an accepted start, adds the
    // byte on the bus each time a data byte is strobed.
    always_ff @(posedge clk24MHz or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == S_IDLE && start) begin
            sum_q <= '0;
        end else if (state == S_STROBE_HI || state == S_STROBE_LO) begin
            sum_q <= sum_q + dout_q;
        end
    end
`endif

    // Control outputs registered from the next state (glitch-free strobes).
    always_ff @(posedge clk24MHz or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            noe_q  <= 1'b1;
            nwr_q  <= 1'b1;
            doe_q  <= 1'b0;
        end else begin
            busy_q <= (state_next != S_IDLE) && (state_next != S_DONE);
            done_q <= (state_next == S_DONE);
            noe_q  <= !((state_next == S_RD) || (state_next == S_LATCH));
            nwr_q  <= !((state_next == S_STROBE_HI) ||
                        (state_next == S_STROBE_LO) ||
                        (state_next == S_CK_STROBE));
            doe_q  <= (state_next == S_WAIT_HI)    ||
                      (state_next == S_STROBE_HI)  ||
                      (state_next == S_RELEASE_HI) ||
                      (state_next == S_WAIT_LO)    ||
                      (state_next == S_STROBE_LO)  ||
                      (state_next == S_RELEASE_LO) ||
                      (state_next == S_CK_WAIT)    ||
                      (state_next == S_CK_STROBE)  ||
                      (state_next == S_CK_RELEASE);
        end
    end

    // Output byte: loaded only on entry to a WAIT state, while nWR is high.
    always_ff @(posedge clk24MHz or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            if (state == S_LATCH) begin
                dout_q <= sram_data[15:8];
            end else if (state == S_RELEASE_HI) begin
                dout_q <= lo_latch_q;
            end
`ifdef READBACK_CHECKSUM_EN
            else if (state == S_NEXT && state_next == S_CK_WAIT) begin
                dout_q <= sum_q;
            end
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sram_addr    = addr_q;
    assign sram_nOE     = noe_q;
    assign ft240x_nWR   = nwr_q;
    assign ft240x_d_out = dout_q;
    assign ft240x_d_oe  = doe_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_sram_readback_tx.sv
// Directed bench for sram_readback_tx: basic read, FIFO-full stall,
// count of zero, address wrap, reset mid-transfer, start during done.
`timescale 1ns/1ps

module tb_sram_readback_tx;

`ifdef READBACK_CHECKSUM_EN
    localparam int CK = 3;
`else
    localparam int CK = 0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #21 clk = ~clk;

    logic        start = 1'b0;
    logic [17:0] start_addr = '0;
    logic [7:0]  word_count = '0;
    logic        busy, done, sram_nOE, ft240x_nWR, ft240x_d_oe;
    logic [17:0] sram_addr;
    logic [15:0] sram_data;
    logic        ft240x_TXE = 1'b0;
    logic [7:0]  ft240x_d_out;
    logic [3:0]  dbg_state;

    logic [15:0] mem [0:(1<<18)-1];
    assign sram_data = mem[sram_addr];

    sram_readback_tx dut (
        .clk24MHz     (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .sram_addr    (sram_addr),
        .sram_nOE     (sram_nOE),
        .sram_data    (sram_data),
        .ft240x_TXE   (ft240x_TXE),
        .ft240x_nWR   (ft240x_nWR),
        .ft240x_d_out (ft240x_d_out),
        .ft240x_d_oe  (ft240x_d_oe),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  ck_sum;
    int          cyc;
    int          busy_cnt;
    logic [17:0] addr_c10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture each byte on the nWR falling edge.
    always @(negedge ft240x_nWR) begin
        if (reset === 1'b0) got_q.push_back(ft240x_d_out);
    end

    // Strobe width, setup and hold, checked once per cycle.
    logic       prev_nwr = 1'b1;
    logic [7:0] prev_dout = '0;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (ft240x_nWR === 1'b0) begin
                check("nwr_width", {31'd0, prev_nwr}, 32'd1);
                check("setup_data", {24'd0, ft240x_d_out}, {24'd0, prev_dout});
                check("strobe_doe", {31'd0, ft240x_d_oe}, 32'd1);
            end else if (prev_nwr === 1'b0) begin
                check("hold_data", {24'd0, ft240x_d_out}, {24'd0, prev_dout});
                check("hold_doe", {31'd0, ft240x_d_oe}, 32'd1);
            end
        end
        prev_nwr  = ft240x_nWR;
        prev_dout = ft240x_d_out;
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        ck_sum = ck_sum + w[15:8] + w[7:0];
    endtask

    task automatic push_ck();
        if (CK != 0) exp_q.push_back(ck_sum);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            if (got_q.size() > 0) check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
            else void'(exp_q.pop_front());
        end
        got_q.delete();
        ck_sum = '0;
    endtask

    // Start strobe sampled at edge 0; returns at the negedge of cycle 1.
    task automatic start_xfer(input logic [17:0] a, input logic [7:0] n);
        @(negedge clk);
        start_addr = a;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    // Run to the done pulse (bounded), counting busy cycles.
    task automatic run_xfer(input string tag, input logic [17:0] a, input logic [7:0] n,
                            input int exp_done);
        start_xfer(a, n);
        check({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
        check({tag, "_noe_c1"}, {31'd0, sram_nOE}, 32'd0);
        check({tag, "_addr_c1"}, {14'd0, sram_addr}, {14'd0, a});
        busy_cnt = 1;
        while (done !== 1'b1 && cyc < exp_done + 50) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (cyc == 10) addr_c10 = sram_addr;
        end
        check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < (1 << 18); i++) mem[i] = 16'(i);
        ck_sum = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_noe", {31'd0, sram_nOE}, 32'd1);
        check("rst_nwr", {31'd0, ft240x_nWR}, 32'd1);
        check("rst_dout", {24'd0, ft240x_d_out}, 32'd0);
        check("rst_doe", {31'd0, ft240x_d_oe}, 32'd0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        reset = 1'b0;

        // Basic two-word read.
        mem[18'h10] = 16'h1234;
        mem[18'h11] = 16'hABCD;
        run_xfer("basic", 18'h10, 8'd2, 19 + CK);
        check("basic_addr_w2", {14'd0, addr_c10}, 32'h11);
        push_word(16'h1234);
        push_word(16'hABCD);
        push_ck();
        check_bytes("basic_byte");
        // start in the done cycle is ignored.
        start_addr = 18'h10;
        word_count = 8'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("start_in_done_busy", {31'd0, busy}, 32'd0);
        check("start_in_done_state", {28'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        check("start_in_done_idle", {31'd0, busy}, 32'd0);

        // FIFO full for 5 cycles on entry to WAIT_LO.
        start_xfer(18'h10, 8'd1);
        while (done !== 1'b1 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 6 && cyc <= 11) begin
                check("stall_nwr", {31'd0, ft240x_nWR}, 32'd1);
                check("stall_dout", {24'd0, ft240x_d_out}, 32'h34);
            end
            if (cyc == 5)  ft240x_TXE = 1'b1;
            if (cyc == 11) ft240x_TXE = 1'b0;
        end
        check("stall_done_cycle", cyc, 15 + CK);
        push_word(16'h1234);
        push_ck();
        check_bytes("stall_byte");

        // Count of zero: 256 words from 0x100 with an incrementing pattern.
        run_xfer("cnt0", 18'h100, 8'd0, 9 * 256 + 1 + CK);
        check("cnt0_final_addr", {14'd0, sram_addr}, 32'h200);
        for (int a = 18'h100; a < 18'h200; a++) push_word(16'(a));
        push_ck();
        check_bytes("cnt0_byte");

        // Address wrap.
        mem[18'h3FFFF] = 16'hBEEF;
        mem[18'h00000] = 16'hC0DE;
        run_xfer("wrap", 18'h3FFFF, 8'd2, 19 + CK);
        check("wrap_addr_w2", {14'd0, addr_c10}, 32'h0);
        check("wrap_final_addr", {14'd0, sram_addr}, 32'h1);
        push_word(16'hBEEF);
        push_word(16'hC0DE);
        push_ck();
        check_bytes("wrap_byte");

        // Reset while in STROBE_HI.
        start_xfer(18'h10, 8'd2);
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_state_strobe", {28'd0, dbg_state}, 32'd4);
        check("mid_nwr_low", {31'd0, ft240x_nWR}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_nwr", {31'd0, ft240x_nWR}, 32'd1);
        check("mid_rst_doe", {31'd0, ft240x_d_oe}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_noe", {31'd0, sram_nOE}, 32'd1);
        check("mid_rst_state", {28'd0, dbg_state}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        got_q.delete();
        run_xfer("after_rst", 18'h10, 8'd2, 19 + CK);
        push_word(16'h1234);
        push_word(16'hABCD);
        push_ck();
        check_bytes("after_rst_byte");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of sequence, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_readback_tx.md
# sram_readback_tx

Streams a range of emulation-SRAM words back to the host through the FT240X transmit FIFO, high byte first. This is the write-side counterpart of the FT240X-receive/SRAM-load path, and lets the host verify a loaded image. The block sits in the CPLD beside the command FSM. It is started with a single-cycle strobe and owns the SRAM address/OE and the FT240X WR#/data lines only while busy. The top level muxes its SRAM and FT240X outputs in while `busy`=1; that is valid only in LOAD mode.

## Interface
- `ADDR_W`, 18: SRAM word-address width.
- `CNT_W`, 8: word-count width.
- `clk24MHz` in 1: system clock, the 24 MHz FT240X clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle start strobe. Ignored while `busy`=1.
- `start_addr` in ADDR_W: first word address. Sampled on `start`.
- `word_count` in CNT_W: number of words to send. Sampled on `start`; 0 means 2^CNT_W words.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at the end of the transfer.
- `sram_addr` out ADDR_W: registered SRAM word address.
- `sram_nOE` out 1: SRAM output enable, active low.
- `sram_data` in 16: SRAM read data.
- `ft240x_TXE` in 1: high means the TX FIFO is full; do not write.
- `ft240x_nWR` out 1: FT240X write strobe. Data is taken on the high-to-low edge.
- `ft240x_d_out` out 8: byte presented to the FT240X.
- `ft240x_d_oe` out 1: 1 means the top level drives `ft240x_d` from `ft240x_d_out`.

## Operation
Reset values:
- `busy`=0, `done`=0
- `sram_addr`=0, `sram_nOE`=1
- `ft240x_nWR`=1, `ft240x_d_out`=0, `ft240x_d_oe`=0
- state IDLE, internal counters 0

State machine:
- **IDLE**: On `start`, load the address counter from `start_addr` and the remaining-word counter from `word_count`, then go to RD.
- **RD**: `sram_nOE`=0 and `sram_addr` is stable. Go to LATCH.
- **LATCH**: Capture `sram_data` into a 16-bit word latch. `sram_nOE` stays 0 during this cycle. Go to WAIT_HI.
- **WAIT_HI**: `d_oe`=1, `d_out`=latch[15:8], nWR=1. If TXE=0, go to STROBE_HI; otherwise stay.
- **STROBE_HI**: nWR=0 and data held. Go to RELEASE_HI.
- **RELEASE_HI**: nWR=1 and data held. Go to WAIT_LO.
- **WAIT_LO, STROBE_LO, RELEASE_LO**: Same as the HI states, using latch[7:0].
- **NEXT**: Address +1, wrapping modulo 2^ADDR_W (0x3FFFF → 0x00000). Remaining count −1. If the count before the decrement was 1, go to DONE; otherwise go to RD.
- **DONE**: `done`=1 for one cycle, `busy`=0, `d_oe`=0. Go to IDLE.

General rules:
- `busy`=1 in every state except IDLE and DONE.
- `sram_nOE`=0 only in RD and LATCH.
- `d_oe`=1 from WAIT_x through RELEASE_x. Data changes only while nWR=1.
- TXE is sampled only in the WAIT states. A TXE rise during STROBE or RELEASE does not abort the byte in flight.
- The remaining-word counter is CNT_W+1 bits wide so that a count of 2^CNT_W fits.
- Reset at any point forces all reset values immediately, including nWR=1, with no partial-byte completion.

## Timing
- `start` sampled at edge 0 gives RD in cycle 1.
- One word takes 9 cycles with TXE held low.
- N words with TXE held low: `busy` is high for 9N cycles, and the `done` pulse occurs in cycle 9N+1.
- Each nWR low pulse is exactly one cycle (41.7 ns).
- Data is set up at least one cycle before the nWR falling edge and held at least one cycle after nWR rises.
- Each cycle TXE is high in a WAIT state adds one cycle.
- `start` in the same cycle as `done` is ignored. `start` is accepted only in IDLE.

## Configuration
- `READBACK_CHECKSUM_EN` defined: after the last NEXT, the block passes through CK_WAIT, CK_STROBE and CK_RELEASE, which follow the same rules as the byte states, before DONE.
  - These states send one extra byte: the sum modulo 256 of all data bytes sent.
  - The sum register clears on `start` and accumulates on each STROBE.
  - N-word latency becomes 9N+3 cycles with TXE held low.
- `READBACK_CHECKSUM_EN` undefined: no checksum states or register; the transfer ends at NEXT → DONE.

## Test plan
- **Basic two-word read.** `start_addr`=0x00010, `word_count`=2, SRAM[0x10]=0x1234, SRAM[0x11]=0xABCD, TXE=0 → nWR falling edges with data 0x12, 0x34, 0xAB, 0xCD; `done` in cycle 19; `sram_addr` reads 0x00011 during the second word.
- **FIFO full stall.** Hold TXE=1 for 5 cycles on entry to WAIT_LO → nWR stays 1 and `d_out`=0x34 holds stable for those 5 cycles plus 1; the byte is sent once TXE=0; total latency is +5 cycles.
- **Count of zero.** `word_count`=0 with an incrementing SRAM pattern → 256 words, 512 nWR pulses, address advances by 256.
- **Address wrap.** `start_addr`=0x3FFFF, `word_count`=2 → reads 0x3FFFF then 0x00000.
- **Reset mid-transfer.** Assert `reset` while in STROBE_HI → nWR=1, `d_oe`=0, `busy`=0 within the same cycle, no `done` pulse; a following `start` runs correctly.
- **Checksum enabled.** With `READBACK_CHECKSUM_EN` defined, repeat the basic two-word read → a fifth byte 0xBE is sent; `done` in cycle 22.
